vga_scanout: RTL and testbench
==============================

Name: vga_scanout

Overview:
- Display-side reader of the 400x300, 6-bit-colour frame buffer that the game logic fills.
- Generates 800x600@72 Hz VGA timing directly from clk50M, using the 50 MHz pixel clock with no clock enable.
- Reads the frame buffer with 2x2 pixel replication and drives the RGB and sync pins.
- Produces the write_enable and vertical_porch_start handshakes that gate the game logic's memory writes.

Parameters:
- H_VISIBLE, 800, active pixels per line
- H_FRONT, 56, horizontal front porch (clocks)
- H_SYNC, 120, hsync width (clocks)
- H_BACK, 64, horizontal back porch (clocks)
- V_VISIBLE, 600, active lines per frame
- V_FRONT, 37, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BACK, 23, vertical back porch (lines)
- SYNC_POL, 1, active level of hsync/vsync

Ports:
- clk50M  in  1  pixel/system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- fb_addr_x  out  9  frame-buffer read column, 0..399
- fb_addr_y  out  9  frame-buffer read row, 0..299
- fb_rd  out  1  read strobe; high while in the visible area
- fb_data  in  6  colour {R[1:0],G[1:0],B[1:0]}; valid 1 cycle after address
- vga_r  out  2  red
- vga_g  out  2  green
- vga_b  out  2  blue
- vga_hsync  out  1  horizontal sync
- vga_vsync  out  1  vertical sync
- write_enable  out  1  high during vertical blanking; game may write the frame buffer
- vertical_porch_start  out  1  1-cycle pulse at start of vertical front porch

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOTAL-1, with H_TOTAL = 1040.
  - v_cnt runs 0..V_TOTAL-1, with V_TOTAL = 666.
  - h_cnt increments every clock and wraps to 0. v_cnt increments on h_cnt wrap and wraps to 0 after 665.
  - Frame length is 692640 clocks.
- Stage 0 (counter registers):
  - visible = h_cnt < 800 && v_cnt < 600.
  - When visible: fb_addr_x = h_cnt[9:1], fb_addr_y = v_cnt[9:1], fb_rd = 1. Otherwise addresses are 0 and fb_rd = 0. All three are combinational from the counters.
- Stage 1: visible, hsync_raw and vsync_raw are delayed one register.
  - hsync_raw is active for h_cnt in [856, 975].
  - vsync_raw is active for v_cnt in [637, 642].
- Stage 2 (output registers):
  - vga_r/g/b = fb_data fields when delayed visible, else 0.
  - vga_hsync and vga_vsync are the delayed raw values at SYNC_POL level.
- Latency: the pixel for counter position (h,v) appears on the pins exactly 2 clocks later. Syncs and colour share the same 2-clock delay, so they stay aligned.
- write_enable:
  - Registered. Goes to 1 on the clock after v_cnt becomes 600 (h_cnt=0).
  - Goes to 0 on the clock after v_cnt wraps to 0. It is low for all visible lines.
- vertical_porch_start:
  - Registered 1-clock pulse, asserted in the cycle after the counters reach (h=0, v=600).
  - Exactly one pulse per frame. It is coincident with the write_enable rising edge.
- Each frame-buffer pixel is read on 4 screen positions (2 horizontal clocks x 2 lines). No buffering; re-reads are intended.
- Reset (synchronous, also mid-frame):
  - h_cnt = v_cnt = 0.
  - All pipeline registers cleared.
  - vga_r/g/b = 0; vga_hsync = vga_vsync = ~SYNC_POL.
  - write_enable = 0; vertical_porch_start = 0.
  - The first post-reset clock starts pixel (0,0) of a new frame. No pulse is emitted until v_cnt reaches 600.
- Boundary conditions:
  - fb_data is ignored outside the visible area.
  - fb_addr_x never exceeds 399 and fb_addr_y never exceeds 299.
  - All arithmetic is unsigned. Counter widths: h_cnt 11 bits, v_cnt 10 bits.

Test Plan:
- Free run 2 frames after reset -> hsync period 1040 clocks with an active width of 120; vsync period 692640 clocks with an active width of 6240 clocks (6 lines).
- Monitor vertical_porch_start -> single 1-clock pulse per frame, 692640 clocks apart; first pulse 624001 clocks after rst deasserts (600*1040 + 1 register delay).
- Model fb_data as {x[2:0],y[2:0]} with 1-cycle latency -> pin colour at screen (h=2k+1, v=2m) equals the pixel at (k,m); (h=1,v=1) shows fb pixel (0,0); the hsync edge and the first blank pixel land exactly 2 clocks after the counter boundary.
- Check write_enable over a frame -> 0 for lines 0..599, 1 from line 600 through line 665, and fb_rd never high while write_enable is high.
- Assert rst for 1 clock at v_cnt=300, h_cnt=500 -> next cycle all outputs take their reset values, counters restart at (0,0), and the next porch pulse comes 624001 clocks later.
- Drive fb_data = 6'b111111 constantly -> RGB = 3/3/3 only in the 800x600 window and 0 in all blanking, including h=800..1039 and lines 600..665.

Source files
------------

// File: rtl/vga_scanout.sv
// vga_scanout: 800x600@72 Hz VGA timing generator and frame-buffer reader.
// A 400x300 6-bit frame buffer is shown with 2x2 pixel replication. The
// pipeline is counters -> one register (waiting on the frame-buffer read)
// -> output pins, so colour and syncs leave exactly 2 clocks after the
// counter position that produced them. write_enable and
// vertical_porch_start let the game logic update the frame buffer during
// vertical blanking.
module vga_scanout #(
  parameter int H_VISIBLE = 800,
  parameter int H_FRONT   = 56,
  parameter int H_SYNC    = 120,
  parameter int H_BACK    = 64,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT   = 37,
  parameter int V_SYNC    = 6,
  parameter int V_BACK    = 23,
  parameter bit SYNC_POL  = 1'b1
) (
  input  logic       clk50M,
  input  logic       rst,
  output logic [8:0] fb_addr_x,
  output logic [8:0] fb_addr_y,
  output logic       fb_rd,
  input  logic [5:0] fb_data,
  output logic [1:0] vga_r,
  output logic [1:0] vga_g,
  output logic [1:0] vga_b,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       write_enable,
  output logic       vertical_porch_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Sized boundary constants so every counter comparison is width-exact.
  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS_END    = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYNC_FIRST = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_LAST  = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS_END    = 10'(V_VISIBLE);
  localparam logic [9:0]  V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        h_wrap;
  logic        frame_end;

  // Stage 0 (combinational from the counters)
  logic        visible;
  logic        hsync_raw;
  logic        vsync_raw;

  // Stage 1 (aligned with the cycle in which fb_data is valid)
  logic        visible_d1;
  logic        hsync_d1;
  logic        vsync_d1;

  assign h_wrap    = (h_cnt == H_LAST);
  assign frame_end = h_wrap && (v_cnt == V_LAST);

  // Raster position: h_cnt every clock, v_cnt on each line wrap.
  always_ff @(posedge clk50M) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of block ordering.
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  // Visible window, replicated frame-buffer address and raw sync windows.
  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves
    // a value held, which would otherwise infer a latch.
    fb_addr_x = '0;
    fb_addr_y = '0;
    visible   = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    hsync_raw = (h_cnt >= H_SYNC_FIRST) && (h_cnt <= H_SYNC_LAST);
    vsync_raw = (v_cnt >= V_SYNC_FIRST) && (v_cnt <= V_SYNC_LAST);
    if (visible) begin
      // Dropping bit 0 shows each stored pixel on two clocks and two lines.
      fb_addr_x = h_cnt[9:1];
      fb_addr_y = v_cnt[9:1];
    end
  end

  assign fb_rd = visible;

  // Delay the control bits one clock to wait for the frame-buffer read.
  always_ff @(posedge clk50M) begin
    if (rst) begin
      visible_d1 <= 1'b0;
      hsync_d1   <= 1'b0;
      vsync_d1   <= 1'b0;
    end else begin
      visible_d1 <= visible;
      hsync_d1   <= hsync_raw;
      vsync_d1   <= vsync_raw;
    end
  end

  // Output pins: colour is blanked outside the window, syncs at SYNC_POL.
  always_ff @(posedge clk50M) begin
    if (rst) begin
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      vga_hsync <= ~SYNC_POL;
      vga_vsync <= ~SYNC_POL;
    end else begin
      vga_r     <= visible_d1 ? fb_data[5:4] : 2'b00;
      vga_g     <= visible_d1 ? fb_data[3:2] : 2'b00;
      vga_b     <= visible_d1 ? fb_data[1:0] : 2'b00;
      vga_hsync <= hsync_d1 ? SYNC_POL : ~SYNC_POL;
      vga_vsync <= vsync_d1 ? SYNC_POL : ~SYNC_POL;
    end
  end

  // Blanking handshakes for the game logic. write_enable drops on the same
  // edge that wraps v_cnt, so it never overlaps a frame-buffer read.
  always_ff @(posedge clk50M) begin
    if (rst) begin
      write_enable         <= 1'b0;
      vertical_porch_start <= 1'b0;
    end else begin
      write_enable         <= (v_cnt >= V_VIS_END) && !frame_end;
      vertical_porch_start <= (h_cnt == 11'd0) && (v_cnt == V_VIS_END);
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: drives vga_scanout with a reduced raster geometry so
// several whole frames fit in a short run. A behavioural model derives every
// expected output from the cycle count since reset, and a frame-buffer model
// returns {x[2:0],y[2:0]} ^ seed (or all ones) one cycle after the address,
// with random junk whenever no read is requested.
`timescale 1ns/1ps
module tb_vga_scanout;

  localparam int HV = 40, HF = 6, HS = 8, HB = 6;
  localparam int VV = 20, VF = 3, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam bit POL = 1'b1;

  logic       clk50M = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] fb_data = '0;
  logic [8:0] fb_addr_x, fb_addr_y;
  logic       fb_rd;
  logic [1:0] vga_r, vga_g, vga_b;
  logic       vga_hsync, vga_vsync;
  logic       write_enable, vertical_porch_start;

  vga_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(POL)
  ) dut (
    .clk50M(clk50M),
    .rst(rst),
    .fb_addr_x(fb_addr_x),
    .fb_addr_y(fb_addr_y),
    .fb_rd(fb_rd),
    .fb_data(fb_data),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync),
    .write_enable(write_enable),
    .vertical_porch_start(vertical_porch_start)
  );

  always #10 clk50M = ~clk50M;

  int n_checks = 0;
  int n_fail = 0;
  int n = 0;          // clocks since the last reset edge
  int cyc = 0;        // absolute clock count
  int mode = 0, next_mode = 0;
  logic [5:0] seed = '0, next_seed = '0;

  logic       mem_rd = 1'b0;
  logic [8:0] mem_x = '0, mem_y = '0;

  int last_vps = -1, hs_rise = -1, vs_rise = -1;
  bit prev_hs = 1'b0, prev_vs = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (n=%0d)", tag, got, exp, n);
    end
  endtask

  function automatic logic [5:0] pix(input int x, input int y);
    if (mode == 1) return 6'h3f;
    return 6'(((x % 8) * 8) + (y % 8)) ^ seed;
  endfunction

  // Expected outputs for the current cycle, from raster arithmetic on n.
  task automatic model_check();
    int h, v, hp, vp, pv;
    bit vis, visp, hs, vs, we, vps;
    logic [5:0] rgb;
    h   = n % HT;
    v   = (n / HT) % VT;
    vis = (h < HV) && (v < VV);
    check("fb_rd", 32'(fb_rd), 32'(vis));
    check("fb_addr_x", 32'(fb_addr_x), vis ? 32'(h / 2) : 32'd0);
    check("fb_addr_y", 32'(fb_addr_y), vis ? 32'(v / 2) : 32'd0);

    rgb = '0; hs = 1'b0; vs = 1'b0;
    if (n >= 2) begin
      hp   = (n - 2) % HT;
      vp   = ((n - 2) / HT) % VT;
      visp = (hp < HV) && (vp < VV);
      rgb  = visp ? pix(hp / 2, vp / 2) : 6'd0;
      hs   = (hp >= HV + HF) && (hp < HV + HF + HS);
      vs   = (vp >= VV + VF) && (vp < VV + VF + VS);
    end
    check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(rgb));
    check("hsync", 32'(vga_hsync), 32'(hs ? POL : !POL));
    check("vsync", 32'(vga_vsync), 32'(vs ? POL : !POL));

    we = 1'b0; vps = 1'b0;
    if (n >= 1) begin
      pv  = ((n - 1) / HT) % VT;
      we  = (pv >= VV) && (v != 0);
      vps = ((n - 1) % HT == 0) && (pv == VV);
    end
    check("write_enable", 32'(write_enable), 32'(we));
    check("porch_pulse", 32'(vertical_porch_start), 32'(vps));
  endtask

  // Interval checks on the pins: pulse spacing, sync periods and widths.
  task automatic track();
    bit hs_act, vs_act;
    if (vertical_porch_start) begin
      if (last_vps < 0) check("porch_first_delay", 32'(n), 32'(VV * HT + 1));
      else              check("porch_period", 32'(cyc - last_vps), 32'(FRAME));
      last_vps = cyc;
    end
    hs_act = (vga_hsync == POL);
    if (hs_act && !prev_hs) begin
      if (hs_rise >= 0) check("hsync_period", 32'(cyc - hs_rise), 32'(HT));
      hs_rise = cyc;
    end
    if (!hs_act && prev_hs && hs_rise >= 0) check("hsync_width", 32'(cyc - hs_rise), 32'(HS));
    prev_hs = hs_act;
    vs_act = (vga_vsync == POL);
    if (vs_act && !prev_vs) begin
      if (vs_rise >= 0) check("vsync_period", 32'(cyc - vs_rise), 32'(FRAME));
      vs_rise = cyc;
    end
    if (!vs_act && prev_vs && vs_rise >= 0) check("vsync_width", 32'(cyc - vs_rise), 32'(VS * HT));
    prev_vs = vs_act;
  endtask

  // One clock: advance the model, drive rst and the frame-buffer reply,
  // then sample and check on the falling edge.
  task automatic tick(input bit do_rst);
    @(posedge clk50M);
    cyc++;
    if (rst) begin
      n = 0;
      mode = next_mode;
      seed = next_seed;
      last_vps = -1; hs_rise = -1; vs_rise = -1;
      prev_hs = 1'b0; prev_vs = 1'b0;
    end else begin
      n++;
    end
    #1;
    rst = do_rst;
    fb_data = mem_rd ? pix(int'(mem_x), int'(mem_y)) : 6'($urandom);
    @(negedge clk50M);
    mem_rd = fb_rd;
    mem_x  = fb_addr_x;
    mem_y  = fb_addr_y;
    model_check();
    track();
  endtask

  initial begin
    int pos;
    bit hit;
    next_mode = 0;
    next_seed = 6'($urandom);

    // Power-on reset, then two full frames of free running.
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    repeat (2 * FRAME + 20) tick(1'b0);

    // One-clock reset in the middle of a visible line of the middle row.
    pos = (VV / 2) * HT + int'($urandom_range(HV - 1, 1));
    next_seed = 6'($urandom);
    hit = 1'b0;
    for (int i = 0; i < FRAME + 1 && !hit; i++) begin
      if ((n + 1) % FRAME == pos) begin
        tick(1'b1);
        hit = 1'b1;
      end else begin
        tick(1'b0);
      end
    end
    check("mid_reset_reached", 32'(hit), 32'd1);
    repeat (FRAME + 20) tick(1'b0);

    // Constant white frame buffer: colour only inside the visible window.
    next_mode = 1;
    tick(1'b1);
    repeat (FRAME + 20) tick(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
